// File: rtl/clock_div_gen.sv
// clock_div_gen: multi-channel programmable refclk divider with glitch-free period-boundary updates
module clock_div_gen #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 8,
  parameter int RESET_DIV = 4
) (
  input  logic                    refclk,
  input  logic                    rst,
  input  logic [NUM_CH*DIV_W-1:0] div_val,
  input  logic [NUM_CH-1:0]       div_load,
  input  logic [NUM_CH-1:0]       ch_en,
  output logic [NUM_CH-1:0]       clk_out,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       busy
);
  typedef enum logic [1:0] {STOP, RUN, DRAIN} state_e;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    state_e           state_q, state_d;
    logic [DIV_W-1:0] cnt_q, cnt_d, act_q, act_d, pend_q, pend_d, ld_val, raw;
    logic [DIV_W:0]   half;
    logic             pend_v_q, pend_v_d, clk_q, clk_d, tick_q, tick_d, running, wrap;
    always_comb begin
      raw      = div_val[i*DIV_W +: DIV_W];
      ld_val   = raw < DIV_W'(2) ? DIV_W'(2) : raw;
      running  = state_q != STOP;
      wrap     = running && cnt_q == act_q - 1'b1;
      // an enable seen at a wrap keeps the channel running, so DRAIN->RUN wins over DRAIN->STOP
      state_d  = !running ? (ch_en[i] ? RUN : STOP) : ch_en[i] ? RUN : wrap ? STOP : DRAIN;
      cnt_d    = (!running || wrap) ? '0 : cnt_q + 1'b1;
      act_d    = !running ? (div_load[i] ? ld_val : act_q)
               : wrap ? (div_load[i] ? ld_val : pend_v_q ? pend_q : act_q) : act_q;
      pend_d   = (running && !wrap && div_load[i]) ? ld_val : pend_q;
      pend_v_d = running && !wrap && (div_load[i] || pend_v_q);
      half     = ({1'b0, act_d} + 1'b1) >> 1;
      clk_d    = state_d != STOP && {1'b0, cnt_d} < half;
      tick_d   = state_d != STOP && cnt_d == '0;
    end
    always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
        state_q  <= STOP;
        cnt_q    <= '0;
        act_q    <= DIV_W'(RESET_DIV);
        pend_q   <= '0;
        pend_v_q <= 1'b0;
        clk_q    <= 1'b0;
        tick_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        cnt_q    <= cnt_d;
        act_q    <= act_d;
        pend_q   <= pend_d;
        pend_v_q <= pend_v_d;
        clk_q    <= clk_d;
        tick_q   <= tick_d;
      end
    end
    assign clk_out[i] = clk_q;
    assign tick[i]    = tick_q;
    assign busy[i]    = pend_v_q;
  end
endmodule

// File: tb/tb_clock_div_gen.sv
// tb_clock_div_gen: randomized scoreboard bench; the model emits whole period waveforms per channel
module tb_clock_div_gen;
  localparam int NUM_CH = 2, DIV_W = 8, RESET_DIV = 4;
  logic refclk = 1'b0, rst = 1'b1;
  logic [NUM_CH*DIV_W-1:0] div_val = '0;
  logic [NUM_CH-1:0] div_load = '0, ch_en = '0, en_r = '0, ld_r;
  logic [NUM_CH*DIV_W-1:0] v_r;
  logic [NUM_CH-1:0] clk_out, tick, busy;
  typedef struct packed {logic [NUM_CH-1:0] clk, tick, busy;} exp_t;
  exp_t sb[$];
  int checks = 0, failures = 0;
  bit [1:0] rem[NUM_CH][$];
  int act[NUM_CH], pend[NUM_CH];
  bit pend_v[NUM_CH], run[NUM_CH];

  clock_div_gen #(.NUM_CH(NUM_CH), .DIV_W(DIV_W), .RESET_DIV(RESET_DIV)) dut (
    .refclk(refclk), .rst(rst), .div_val(div_val), .div_load(div_load), .ch_en(ch_en),
    .clk_out(clk_out), .tick(tick), .busy(busy));

  always #5 refclk = ~refclk;

  function automatic void chk(string n, logic [NUM_CH-1:0] got, logic [NUM_CH-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%b exp=%b t=%0t", n, got, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      act[c] = RESET_DIV; pend_v[c] = 0; run[c] = 0; rem[c].delete();
    end
  endfunction

  function automatic void start_period(int c);
    for (int k = 0; k < act[c]; k++) rem[c].push_back({k == 0, k < (act[c] + 1) / 2});
  endfunction

  function automatic logic [15:0] pack(int a1, int a0);
    return {a1[7:0], a0[7:0]};
  endfunction

  // The enable level at a period's final edge alone decides whether another period follows.
  task automatic step(input logic [NUM_CH-1:0] en, input logic [NUM_CH-1:0] ld, input logic [NUM_CH*DIV_W-1:0] v);
    exp_t e;
    bit [1:0] s;
    int nv;
    @(negedge refclk);
    rst = 0; ch_en = en; div_load = ld; div_val = v; e = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      nv = int'(v[c*DIV_W +: DIV_W]);
      nv = nv < 2 ? 2 : nv;
      s = 2'b00;
      if (!run[c]) begin
        if (ld[c]) act[c] = nv;
        if (en[c]) begin run[c] = 1; start_period(c); end
      end else if (rem[c].size() == 0) begin
        act[c] = ld[c] ? nv : pend_v[c] ? pend[c] : act[c];
        pend_v[c] = 0;
        if (en[c]) start_period(c); else run[c] = 0;
      end else if (ld[c]) begin
        pend[c] = nv; pend_v[c] = 1;
      end
      if (run[c]) s = rem[c].pop_front();
      e.tick[c] = s[1]; e.clk[c] = s[0]; e.busy[c] = pend_v[c];
    end
    sb.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge refclk);
      #1;
      if (!rst) begin
        if (sb.size() == 0) chk("underflow", 1'b1, 1'b0);
        else begin
          e = sb.pop_front();
          chk("clk_out", clk_out, e.clk);
          chk("tick", tick, e.tick);
          chk("busy", busy, e.busy);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    repeat (2) @(negedge refclk);
    chk("rst_clk", clk_out, '0);
    chk("rst_tick", tick, '0);
    chk("rst_busy", busy, '0);
    repeat (12) step(2'b01, 2'b00, '0);
    repeat (3) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b10, pack(3, 0));
    repeat (10) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b10, pack(7, 0));
    repeat (20) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b01, pack(0, 0));
    repeat (8) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b01, pack(0, 1));
    repeat (8) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b01, pack(0, 6));
    for (int i = 0; i < 40 && !(act[0] == 6 && rem[0].size() == 4); i++) step(2'b11, 2'b00, '0);
    repeat (10) step(2'b10, 2'b00, '0);
    repeat (8) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b10, pack(8, 0));
    for (int i = 0; i < 40 && !(act[1] == 8 && rem[1].size() == 6); i++) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b10, pack(5, 0));
    step(2'b11, 2'b10, pack(9, 0));
    repeat (24) step(2'b11, 2'b00, '0);
    for (int i = 0; i < 40 && rem[1].size() != 0; i++) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b10, pack(5, 0));
    repeat (12) step(2'b11, 2'b00, '0);
    for (int i = 0; i < 40 && rem[1].size() < 2; i++) step(2'b11, 2'b00, '0);
    step(2'b11, 2'b10, pack(200, 0));
    step(2'b11, 2'b00, '0);
    @(posedge refclk);
    #2 rst = 1;
    #1;
    chk("arst_clk", clk_out, '0);
    chk("arst_tick", tick, '0);
    chk("arst_busy", busy, '0);
    model_reset();
    repeat (3) @(negedge refclk);
    repeat (16) step(2'b11, 2'b00, '0);
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if ($urandom_range(0, 15) == 0) en_r[c] = ~en_r[c];
        ld_r[c] = $urandom_range(0, 9) == 0;
        v_r[c*DIV_W +: DIV_W] = DIV_W'($urandom_range(0, 3) == 0 ? $urandom_range(0, 255) : $urandom_range(0, 12));
      end
      step(en_r, ld_r, v_r);
    end
    @(posedge refclk);
    #2;
    chk("drained", NUM_CH'(sb.size()), '0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/clock_div_gen.md
Name: clock_div_gen

Overview:
- Parametrised multi-channel programmable clock-enable/clock generator, all channels clocked from refclk.
- Each channel divides refclk by a runtime-loadable integer N and produces a flop-driven divided clock plus a one-cycle rising-edge strobe.
- Divisor changes and enable/disable take effect only at period boundaries, so no runt pulses. Feeds audio/peripheral timing logic.

Parameters:
- NUM_CH, 2, number of independent divider channels
- DIV_W, 8, divisor width in bits; legal N range 2..2^DIV_W-1
- RESET_DIV, 4, active divisor of every channel after reset (must be >=2)

Ports:
- refclk  in  1  reference clock; all logic on rising edge
- rst  in  1  asynchronous, active-high reset
- div_val  in  NUM_CH*DIV_W  per-channel divisor; channel i uses bits [i*DIV_W +: DIV_W]
- div_load  in  NUM_CH  per-channel one-cycle load strobe for div_val
- ch_en  in  NUM_CH  per-channel run enable (level)
- clk_out  out  NUM_CH  divided clock, driven directly from a flop
- tick  out  NUM_CH  one-refclk pulse coincident with each clk_out rising cycle
- busy  out  NUM_CH  divisor change pending, not yet applied

Behaviour:
- Reset (async assert, sync use after release), per channel:
  - state=STOP, cnt=0, active divisor=RESET_DIV, pending cleared
  - clk_out=0, tick=0, busy=0
- Per-channel counter cnt counts 0..N-1 in RUN/DRAIN. Wrap = edge where cnt goes N-1 -> 0.
- High length H = ceil(N/2).
- clk_out and tick are registered. In the cycle where cnt==k: clk_out=(k<H) and tick=(k==0) while RUN or DRAIN.
  - N=2: 1,0
  - N=3: 1,1,0
  - N=4: 1,1,0,0
- Loaded divisor <2 is clamped to 2. Arithmetic is unsigned DIV_W-bit, with no overflow since cnt <= N-1.
- State machine per channel:
  - STOP -> RUN: on an edge with ch_en=1. In the first RUN cycle, cnt=0, clk_out=1, tick=1.
  - RUN -> DRAIN: on an edge with ch_en=0 and no wrap. The current period continues unchanged.
  - RUN -> STOP: at a wrap edge with ch_en=0, when ch_en drops exactly at the end of a period.
  - DRAIN -> RUN: on an edge with ch_en=1. The period continues without phase disturbance.
  - DRAIN -> STOP: at the wrap edge. Then cnt=0, clk_out=0, tick=0.
  - STOP holds clk_out=0, cnt=0.
- Divisor load, in RUN/DRAIN:
  - div_load=1 captures clamp(div_val) into pending and sets busy=1 next cycle.
  - Pending is copied to active at the next wrap edge, where busy clears. The new period starts with the new N.
- Load in the same cycle as a wrap: value goes straight to active at that edge; busy stays 0.
- Load while busy: the newer value overwrites pending, and only the last value is applied.
- Load while in STOP: active updated at the next edge, busy stays 0.
- Reset mid-operation: immediate return to reset values; pending load is lost.
- Channels are fully independent; no inter-channel phase relationship is guaranteed unless enabled on the same edge with equal N.
- Latency: ch_en rise -> clk_out/tick high on the first edge after it is sampled (1 cycle).

Test Plan:
- Reset release, ch0 ch_en=1, no loads -> clk_out[0] = 1,1,0,0 repeating (RESET_DIV=4); tick[0] every 4th cycle starting the first enabled cycle; busy=0.
- Load N=3 then N=7 on ch1 while running -> period 3 = 1,1,0; period 7 = four high, three low; each change lands exactly at a wrap; busy high from the load until the wrap.
- Load N=0 and N=1 -> clamped, channel runs at N=2 (1,0).
- ch_en drop mid-period at cnt=1, N=6 -> clk_out completes 1,1,1,0,0,0 then holds 0, state STOP; re-enable -> restarts at cnt=0 with tick.
- Two loads (5 then 9) while busy with N=8 -> only 9 applied at the next wrap; load coincident with wrap -> applied immediately, busy never asserts.
- Async rst asserted mid-period with busy=1 -> all outputs 0 immediately; after release, RESET_DIV resumes and the pending value is discarded.
